// File: rtl/sub_64_pkg.sv
// Shared defaults for the 64-bit add/subtract pipeline family.
//   DEF_WIDTH  : operand/result width
//   DEF_SLICE  : bits resolved per pipeline stage
//   DEF_STAGES : pipeline depth for the defaults
package sub_64_pkg;

    localparam int DEF_WIDTH  = 64;
    localparam int DEF_SLICE  = 16;
    localparam int DEF_STAGES = DEF_WIDTH / DEF_SLICE;

endpackage

// File: rtl/sub_64_slice.sv
// sub_slice: one registered SLICE-bit subtract stage, a - b - borrow_in,
// computed as a + ~b + ~borrow_in.
//   clk, rst_n          : clock, async active-low reset
//   a, b, borrow_in     : operand slice and borrow from the previous stage
//   vld_in              : item valid at this stage's input
//   diff, borrow_out    : registered result slice and borrow (hold when idle)
//   vld_out             : registered valid
module sub_slice
    import sub_64_pkg::*;
#(
    parameter int SLICE = DEF_SLICE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             borrow_in,
    input  logic             vld_in,
    output logic [SLICE-1:0] diff,
    output logic             borrow_out,
    output logic             vld_out
);

    logic [SLICE:0] sum;

    // Carry out of a + ~b + ~borrow_in is the inverse of the borrow out.
    assign sum = {1'b0, a} + {1'b0, ~b} + {{SLICE{1'b0}}, ~borrow_in};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff       <= '0;
            borrow_out <= 1'b0;
            vld_out    <= 1'b0;
        end else begin
            vld_out <= vld_in;
            // Only valid items update the data, so idle slots leave the
            // previous result in place all the way to the outputs.
            if (vld_in) begin
                diff       <= sum[SLICE-1:0];
                borrow_out <= ~sum[SLICE];
            end
        end
    end

endmodule

// File: rtl/sub_64.sv
// sub_64: pipelined subtractor, diff = a - b - borrow_in (mod 2^WIDTH).
// One SLICE-bit slice is resolved per stage, borrow ripples stage to stage.
// Operands are registered on din_en, then pass through STAGES slice stages,
// so results appear STAGES edges after the sampling edge.
//   clk, rst_n             : clock, async active-low reset
//   a_in, b_in, borrow_in  : operands, sampled when din_en=1
//   din_en                 : input valid strobe
//   diff_out, borrow_out   : result and unsigned borrow of the top slice
//   ovf_out                : signed overflow of the subtraction
//   dout_en                : output valid strobe, one per accepted input
// WIDTH must be a multiple of SLICE and give at least two stages.
module sub_64
    import sub_64_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SLICE = DEF_SLICE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             borrow_in,
    input  logic             din_en,
    output logic [WIDTH-1:0] diff_out,
    output logic             borrow_out,
    output logic             ovf_out,
    output logic             dout_en
);

    localparam int STAGES = WIDTH / SLICE;
    localparam int LAST   = STAGES - 1;

    logic              vld_in_r;
    logic [STAGES:0]   vld_pipe;  // valid of the item at each register level
    logic [1:0]        sgn;       // {a msb, b msb} of the item at the outputs

    assign vld_pipe[0] = vld_in_r;

    for (genvar k = 0; k < STAGES; k++) begin : st
        // Operand bits not yet consumed: slice k sits in the low SLICE bits.
        logic [WIDTH-k*SLICE-1:0] a_lv;
        logic [WIDTH-k*SLICE-1:0] b_lv;
        logic                     bin;
        logic [SLICE-1:0]         d_o;
        logic                     bo;

        if (k == 0) begin : g_src
            logic bin_r;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_lv     <= '0;
                    b_lv     <= '0;
                    bin_r    <= 1'b0;
                    vld_in_r <= 1'b0;
                end else begin
                    vld_in_r <= din_en;
                    if (din_en) begin
                        a_lv  <= a_in;
                        b_lv  <= b_in;
                        bin_r <= borrow_in;
                    end
                end
            end

            assign bin = bin_r;
        end else begin : g_src
            // Operand skew: drop the slice consumed by the previous stage.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_lv <= '0;
                    b_lv <= '0;
                end else if (vld_pipe[k-1]) begin
                    a_lv <= st[k-1].a_lv[WIDTH-(k-1)*SLICE-1:SLICE];
                    b_lv <= st[k-1].b_lv[WIDTH-(k-1)*SLICE-1:SLICE];
                end
            end

            assign bin = st[k-1].bo;
        end

        sub_slice #(.SLICE(SLICE)) u_slice (
            .clk        (clk),
            .rst_n      (rst_n),
            .a          (a_lv[SLICE-1:0]),
            .b          (b_lv[SLICE-1:0]),
            .borrow_in  (bin),
            .vld_in     (vld_pipe[k]),
            .diff       (d_o),
            .borrow_out (bo),
            .vld_out    (vld_pipe[k+1])
        );

        // Result skew: slices 0..k-1, aligned with this stage's output slice.
        if (k > 0) begin : g_res
            logic [k*SLICE-1:0] res_lo;
            logic [k*SLICE-1:0] res_src;

            if (k == 1) begin : g_first
                assign res_src = st[0].d_o;
            end else begin : g_rest
                assign res_src = {st[k-1].d_o, st[k-1].g_res.res_lo};
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    res_lo <= '0;
                else if (vld_pipe[k])
                    res_lo <= res_src;
            end
        end
    end

    // Sign bits ride alongside the last stage so overflow uses the same item.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sgn <= 2'b00;
        else if (vld_pipe[LAST])
            sgn <= {st[LAST].a_lv[SLICE-1], st[LAST].b_lv[SLICE-1]};
    end

    assign diff_out   = {st[LAST].d_o, st[LAST].g_res.res_lo};
    assign borrow_out = st[LAST].bo;
    assign dout_en    = vld_pipe[STAGES];
    assign ovf_out    = (sgn[1] != sgn[0]) && (diff_out[WIDTH-1] != sgn[1]);

endmodule
